// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer around a 1-bit ALU slice: latches an operand pair and opcode,
// walks the slice LSB first, and assembles the WIDTH-bit result with its flags.
module alu_serial_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       ALUop,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             CarryOut,
   output logic             Overflow,
   output logic             op_err,
   output logic             slice_a,
   output logic             slice_b,
   output logic             slice_CarryIn,
   output logic [3:0]       slice_ALUop,
   input  logic             slice_Result,
   input  logic             slice_CarryOut
);

   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic logic op_supported(input logic [3:0] op);
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: return 1'b1;
         default:                                      return 1'b0;
      endcase
   endfunction

   // Subtract-style ops need the two's-complement +1 injected at bit 0.
   function automatic logic op_subtracts(input logic [3:0] op);
      case (op)
         OP_SUB, OP_SLT: return 1'b1;
         default:        return 1'b0;
      endcase
   endfunction

   function automatic logic op_arith(input logic [3:0] op);
      case (op)
         OP_ADD, OP_SUB: return 1'b1;
         default:        return 1'b0;
      endcase
   endfunction

   function automatic logic op_has_carry(input logic [3:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_SLT: return 1'b1;
         default:                return 1'b0;
      endcase
   endfunction

   // The slice has no compare mode; SLT is a subtraction whose sign is fixed up here.
   function automatic logic [3:0] slice_op_of(input logic [3:0] op);
      case (op)
         OP_SLT:  return OP_SUB;
         default: return op;
      endcase
   endfunction

   state_t           state_r, state_s;
   logic [IW-1:0]    idx_r, idx_s;
   logic             carry_r, carry_s;
   logic [WIDTH-1:0] a_r, a_s;
   logic [WIDTH-1:0] b_r, b_s;
   logic [3:0]       op_r, op_s;
   logic [WIDTH-1:0] res_r, res_s;
   logic [WIDTH-1:0] result_r, result_s;
   logic             zero_r, zero_s;
   logic             cout_r, cout_s;
   logic             ovf_r, ovf_s;
   logic             operr_r, operr_s;
   logic             done_r, done_s;
   logic             busy_r, busy_s;
   logic             sa_r, sa_s;
   logic             sb_r, sb_s;
   logic             scin_r, scin_s;
   logic [3:0]       sop_r, sop_s;
   logic             ovf_bit_s;

   // Next-state and next-output logic; slice drives are precomputed so they come from flops.
   always_comb begin
      state_s   = state_r;
      idx_s     = idx_r;
      carry_s   = carry_r;
      a_s       = a_r;
      b_s       = b_r;
      op_s      = op_r;
      res_s     = res_r;
      result_s  = result_r;
      zero_s    = zero_r;
      cout_s    = cout_r;
      ovf_s     = ovf_r;
      operr_s   = operr_r;
      done_s    = 1'b0;
      busy_s    = 1'b0;
      sa_s      = 1'b0;
      sb_s      = 1'b0;
      scin_s    = 1'b0;
      sop_s     = 4'b0000;
      ovf_bit_s = carry_r ^ slice_CarryOut;

      case (state_r)
         IDLE: begin
            if (start) begin
               if (op_supported(ALUop)) begin
                  state_s = RUN;
                  busy_s  = 1'b1;
                  idx_s   = '0;
                  carry_s = op_subtracts(ALUop);
                  a_s     = a;
                  b_s     = b;
                  op_s    = ALUop;
                  sa_s    = a[0];
                  sb_s    = b[0];
                  scin_s  = op_subtracts(ALUop);
                  sop_s   = slice_op_of(ALUop);
               end else begin
                  done_s   = 1'b1;
                  operr_s  = 1'b1;
                  result_s = '0;
                  zero_s   = 1'b0;
                  cout_s   = 1'b0;
                  ovf_s    = 1'b0;
               end
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            res_s[idx_r] = slice_Result;
            carry_s      = slice_CarryOut;
            idx_s        = idx_r + IDX_ONE;
            if (idx_r == IDX_LAST) begin
               state_s = IDLE;
               done_s  = 1'b1;
               idx_s   = '0;
               carry_s = 1'b0;
               if (op_r == OP_SLT) begin
                  result_s = {{(WIDTH-1){1'b0}}, slice_Result ^ ovf_bit_s};
               end else begin
                  result_s = res_s;
               end
               zero_s  = (result_s == '0);
               cout_s  = op_has_carry(op_r) ? slice_CarryOut : 1'b0;
               ovf_s   = op_arith(op_r) ? ovf_bit_s : 1'b0;
               operr_s = 1'b0;
            end else begin
               busy_s = 1'b1;
               sa_s   = a_r[idx_s];
               sb_s   = b_r[idx_s];
               scin_s = slice_CarryOut;
               sop_s  = slice_op_of(op_r);
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         idx_r    <= '0;
         carry_r  <= 1'b0;
         a_r      <= '0;
         b_r      <= '0;
         op_r     <= 4'b0000;
         res_r    <= '0;
         result_r <= '0;
         zero_r   <= 1'b0;
         cout_r   <= 1'b0;
         ovf_r    <= 1'b0;
         operr_r  <= 1'b0;
         done_r   <= 1'b0;
         busy_r   <= 1'b0;
         sa_r     <= 1'b0;
         sb_r     <= 1'b0;
         scin_r   <= 1'b0;
         sop_r    <= 4'b0000;
      end else begin
         state_r  <= state_s;
         idx_r    <= idx_s;
         carry_r  <= carry_s;
         a_r      <= a_s;
         b_r      <= b_s;
         op_r     <= op_s;
         res_r    <= res_s;
         result_r <= result_s;
         zero_r   <= zero_s;
         cout_r   <= cout_s;
         ovf_r    <= ovf_s;
         operr_r  <= operr_s;
         done_r   <= done_s;
         busy_r   <= busy_s;
         sa_r     <= sa_s;
         sb_r     <= sb_s;
         scin_r   <= scin_s;
         sop_r    <= sop_s;
      end
   end

   assign busy          = busy_r;
   assign done          = done_r;
   assign Result        = result_r;
   assign Zero          = zero_r;
   assign CarryOut      = cout_r;
   assign Overflow      = ovf_r;
   assign op_err        = operr_r;
   assign slice_a       = sa_r;
   assign slice_b       = sb_r;
   assign slice_CarryIn = scin_r;
   assign slice_ALUop   = sop_r;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq at WIDTH=8 with a behavioural 1-bit ALU slice
// closing the loop; table-driven vectors plus hand-written multi-cycle sequences.
module tb_alu_serial_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [3:0]   op;
   logic [W-1:0] opa, opb;
   logic         busy, done, Zero, CarryOut, Overflow, op_err;
   logic [W-1:0] Result;
   logic         slice_a, slice_b, slice_CarryIn, slice_Result, slice_CarryOut;
   logic [3:0]   slice_ALUop;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   alu_serial_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .ALUop(op), .a(opa), .b(opb),
      .busy(busy), .done(done), .Result(Result), .Zero(Zero), .CarryOut(CarryOut),
      .Overflow(Overflow), .op_err(op_err), .slice_a(slice_a), .slice_b(slice_b),
      .slice_CarryIn(slice_CarryIn), .slice_ALUop(slice_ALUop),
      .slice_Result(slice_Result), .slice_CarryOut(slice_CarryOut)
   );

   // Behavioural 1-bit ALU slice.
   logic b_eff, sum_bit;
   always_comb begin
      b_eff          = slice_ALUop[2] ? ~slice_b : slice_b;
      sum_bit        = slice_a ^ b_eff ^ slice_CarryIn;
      slice_CarryOut = (slice_a & b_eff) | (slice_a & slice_CarryIn) | (b_eff & slice_CarryIn);
      case (slice_ALUop)
         4'b0000:          slice_Result = slice_a & slice_b;
         4'b0001:          slice_Result = slice_a | slice_b;
         4'b0010, 4'b0110: slice_Result = sum_bit;
         4'b1100:          slice_Result = ~(slice_a | slice_b);
         default:          slice_Result = 1'b0;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Pulses start for one edge, then waits (bounded) for done; lat counts edges after the start edge.
   task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat, output int busy_cnt, output logic cin0, output logic [3:0] sop0);
      start = 1'b1; op = o; opa = x; opb = y;
      @(posedge clk); #1;
      start = 1'b0;
      cin0 = slice_CarryIn;
      sop0 = slice_ALUop;
      lat = 0;
      busy_cnt = 0;
      while (!done && lat < 50) begin
         if (busy) busy_cnt++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   typedef struct packed {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         z;
      logic         c;
      logic         v;
      logic         err;
   } vec_t;

   vec_t vecs[15];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int         lat, bcnt, quiet_done, quiet_busy;
      logic       cin0;
      logic [3:0] sop0;

      //               op       a      b      res    z     c     v     err
      vecs[0]  = '{4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{4'b0110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{4'b0111, 8'hFE, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{4'b0111, 8'h80, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{4'b0111, 8'h01, 8'hFE, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{4'b0000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{4'b0001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{4'b1100, 8'hF0, 8'h3C, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{4'b0010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{4'b0110, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{4'b0110, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[11] = '{4'b0101, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[12] = '{4'b0010, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[13] = '{4'b1100, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{4'b0001, 8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0};

      reset = 1'b1; start = 1'b0; op = 4'b0000; opa = '0; opb = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs",
            {busy, done, Result, Zero, CarryOut, Overflow, op_err,
             slice_a, slice_b, slice_CarryIn, slice_ALUop}, 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Table: each run starts in the done cycle of the previous one (back-to-back).
      for (int i = 0; i < 15; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt, cin0, sop0);
         check($sformatf("vec%0d_result", i), 32'(Result), 32'(vecs[i].res));
         check($sformatf("vec%0d_flags_zcve", i), {Zero, CarryOut, Overflow, op_err},
               {vecs[i].z, vecs[i].c, vecs[i].v, vecs[i].err});
         check($sformatf("vec%0d_latency", i), lat, vecs[i].err ? 0 : W);
         check($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].err ? 0 : W);
      end

      // Re-pulsed start while busy is ignored; Result/flags hold until completion.
      start = 1'b1; op = 4'b0010; opa = 8'h7F; opb = 8'h01;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; op = 4'b0000; opa = 8'h00; opb = 8'h00;
      @(posedge clk); #1;
      start = 1'b0;
      check("hold_result_mid_run", 32'(Result), 32'h3F);
      check("hold_flags_mid_run", {Zero, CarryOut, Overflow, op_err}, 4'b0000);
      lat = 2;
      while (!done && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check("repulse_latency", lat, W);
      check("repulse_result", 32'(Result), 32'h80);
      check("repulse_overflow", Overflow, 1'b1);
      quiet_done = 0; quiet_busy = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (done) quiet_done++;
         if (busy) quiet_busy++;
      end
      check("repulse_not_queued_done", quiet_done, 0);
      check("repulse_not_queued_busy", quiet_busy, 0);

      // Carry-in and slice opcode on bit 0.
      run_op(4'b0110, 8'h05, 8'h05, lat, bcnt, cin0, sop0);
      check("sub_cin_bit0", cin0, 1'b1);
      check("sub_sliceop_bit0", sop0, 4'b0110);
      run_op(4'b0111, 8'h01, 8'hFE, lat, bcnt, cin0, sop0);
      check("slt_cin_bit0", cin0, 1'b1);
      check("slt_sliceop_bit0", sop0, 4'b0110);
      run_op(4'b0010, 8'h7F, 8'h01, lat, bcnt, cin0, sop0);
      check("add_cin_bit0", cin0, 1'b0);
      @(posedge clk); #1;
      check("done_one_cycle", done, 1'b0);

      // Reset during bit 3 aborts the run with no done pulse.
      start = 1'b1; op = 4'b0010; opa = 8'hFF; opb = 8'h01;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midrun_reset_outputs",
            {busy, done, Result, Zero, CarryOut, Overflow, op_err,
             slice_a, slice_b, slice_CarryIn, slice_ALUop}, 32'h0);
      quiet_done = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (done) quiet_done++;
      end
      check("midrun_reset_no_done", quiet_done, 0);
      run_op(4'b0010, 8'h10, 8'h20, lat, bcnt, cin0, sop0);
      check("after_reset_add", 32'(Result), 32'h30);
      check("after_reset_latency", lat, W);

      // Reset wins over start.
      reset = 1'b1; start = 1'b1; op = 4'b0010; opa = 8'h01; opb = 8'h01;
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0;
      check("reset_beats_start", {busy, done}, 2'b00);
      @(posedge clk); #1;
      check("reset_beats_start_later", {busy, done}, 2'b00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/alu_serial_seq.md
# alu_serial_seq

Bit-serial sequencer for the 1-bit ALU slice. It latches a WIDTH-bit operand pair and opcode, then drives the slice one bit per clock, LSB first. It carries the slice's CarryOut forward in a register and assembles the WIDTH-bit result along with Zero, CarryOut, Overflow and set-less-than. It sits directly upstream and downstream of the 1-bit slice: it feeds the slice's a, b, CarryIn and ALUop inputs and consumes its Result and CarryOut.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- ALUop  in  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- a, b  in  WIDTH  operands, sampled with start
- busy  out  1  high while in RUN
- done  out  1  one-cycle completion pulse
- Result  out  WIDTH  final result, held until the next completion
- Zero, CarryOut, Overflow  out  1  flags, held with Result
- op_err  out  1  last request used an unsupported ALUop, held
- slice_a, slice_b, slice_CarryIn  out  1  drive the slice inputs
- slice_ALUop  out  4  drives the slice opcode
- slice_Result, slice_CarryOut  in  1  slice outputs

## Operation
- FSM states are IDLE and RUN. A bit index idx counts 0..WIDTH-1, and carry_q holds the carry.
- IDLE with start=1:
  - Supported op: latch a, b and ALUop; idx←0; carry_q←1 for SUB/SLT, else 0; go to RUN.
  - Unsupported op: stay in IDLE; next cycle done=1, op_err=1, Result=0, all flags 0.
- RUN, each cycle:
  - slice_a=a_q[idx], slice_b=b_q[idx], slice_CarryIn=carry_q.
  - slice_ALUop=ALUop_q, except SLT drives 0110.
  - At the edge: res_q[idx]←slice_Result, carry_q←slice_CarryOut, idx←idx+1.
- Last bit (idx=WIDTH-1), at the same edge:
  - Result←{slice_Result, res_q[WIDTH-2:0]}. For SLT, Result←{WIDTH-1 zeros, slice_Result^ovf}.
  - ovf = carry_q ^ slice_CarryOut (carry into MSB XOR carry out of MSB).
  - Overflow←ovf for ADD/SUB, else 0.
  - CarryOut←slice_CarryOut for ADD/SUB/SLT, else 0.
  - Zero←(new Result==0). op_err←0. done←1. Return to IDLE.
- In IDLE, slice outputs are driven 0.
- start while busy is ignored; it is not queued.
- Logic ops ignore the carry chain for the flags but still run the full WIDTH cycles. Latency does not depend on the op.

## Timing
- Reset (synchronous) forces IDLE, idx=0, carry_q=0, busy=0, done=0, Result=0, Zero=0, CarryOut=0, Overflow=0, op_err=0 and slice outputs 0. Reset wins over start.
- Reset mid-RUN aborts: no done pulse, and the partial result is discarded.
- Start sampled at edge E0 → busy=1 from E0 to E0+WIDTH → done=1 for exactly the cycle between E0+WIDTH and E0+WIDTH+1.
- Result and flags update at the same edge done rises.
- A new start is accepted at the edge ending the done cycle (back-to-back throughput is WIDTH+1 cycles).
- Unsupported op: done at E0+1, one cycle.
- Result and flags do not change during a subsequent RUN until its completion edge.

## Test plan
Bench: WIDTH=8, with a behavioural 1-bit slice instantiated alongside.
- ADD a=0x7F, b=0x01 → Result=0x80, Overflow=1, CarryOut=0, Zero=0; done exactly 8 cycles after the start edge, busy high for 8 cycles.
- SUB a=0x05, b=0x05 → Result=0x00, Zero=1, CarryOut=1, Overflow=0; slice_CarryIn=1 on bit 0.
- SLT a=0xFE, b=0x01 → Result=0x01. SLT a=0x80, b=0x7F → Result=0x01 (overflow case). SLT a=0x01, b=0xFE → Result=0x00.
- AND a=0xF0, b=0x3C → 0x30. OR → 0xFC. NOR → 0x03. CarryOut=0 and Overflow=0 for all three.
- Reset asserted during bit 3 of an ADD → next cycle busy=0, all outputs 0, no done. A following ADD 0x10+0x20 → 0x30.
- start re-pulsed while busy with other operands → ignored, first result unaffected. ALUop=0101 from IDLE → done at the next cycle, op_err=1, Result=0.
